mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port block RAM (spblockram: 32 x 16, synchronous read) among three requesters.
- Requesters: instruction fetch, data load/store, and an external program loader.
- Fixed priority with a fetch anti-starvation override.
- A load-mode FSM drains the CPU and gives the loader exclusive access.
- Sits between processor_top's fetch/data paths and a unified memory; drives cpu_hold to stall control_unit.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 16, RAM data width
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch overrides data (>=1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
load_mode  input  1  request exclusive loader ownership (level)
ld_req  input  1  loader access request
ld_we  input  1  loader write (1) / read (0)
ld_addr  input  ADDR_W  loader address
ld_wdata  input  DATA_W  loader write data
ld_gnt  output  1  loader granted this cycle
ld_rvalid  output  1  loader read data valid on rdata
dm_req  input  1  data access request
dm_we  input  1  data write (1) / read (0)
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  data write data
dm_gnt  output  1  data granted this cycle
dm_rvalid  output  1  data read data valid on rdata
if_req  input  1  fetch request (read only)
if_addr  input  ADDR_W  fetch address (PC[4:0])
if_gnt  output  1  fetch granted this cycle
if_rvalid  output  1  fetch read data valid on rdata
ram_we  output  1  to RAM mem_write
ram_addr  output  ADDR_W  to RAM address
ram_wdata  output  DATA_W  to RAM write_data
ram_rdata  input  DATA_W  from RAM read_data
rdata  output  DATA_W  ram_rdata pass-through (shared response bus)
cpu_hold  output  1  stall CPU (high in DRAIN and LOAD)

Behaviour:
- Interface: one clock, clk; reset resetn is asynchronous and active-low.
- Reset values:
  - state=RUN, starve_cnt=0.
  - All rvalid=0, all gnt=0, ram_we=0, cpu_hold=0.
  - A read in flight at reset is discarded; no rvalid follows reset release.
- Grants are combinational, same cycle as req.
  - At most one gnt per cycle.
  - The winner's addr/wdata/we drive the RAM. With no winner: ram_we=0, ram_addr=0, ram_wdata=0.
- Read latency: granted read at edge N gives <x>_rvalid=1 during cycle N+1, with rdata valid. Registered owner tag; the rvalid is a 1-cycle pulse.
- Writes produce no rvalid.
- FSM RUN:
  - Loader is never granted.
  - dm wins over if, unless starve_cnt==STARVE_LIMIT; then if wins that cycle.
  - starve_cnt: +1 when if_req && !if_gnt (saturates at STARVE_LIMIT); clears on if_gnt or !if_req.
  - load_mode=1 -> DRAIN.
- FSM DRAIN:
  - No grants; cpu_hold=1.
  - Lasts exactly one cycle, so any RUN-cycle read returns its rvalid.
  - Then -> LOAD if load_mode=1, else -> RUN.
- FSM LOAD:
  - Only the loader is granted (ld_gnt=ld_req); cpu_hold=1.
  - dm_req/if_req are ignored and starve_cnt is held at 0.
  - load_mode=0 -> RUN. A loader grant in the same cycle still completes, and its rvalid still fires next cycle.
  - In the first RUN cycle, cpu_hold=0.
- Simultaneous events:
  - load_mode rises in the same cycle as a dm/if request: that cycle is still RUN, and the grant is honored.
  - Back-to-back reads from different requesters are legal every cycle; the tags never collide.
- Fetch/data same-address write+read in one cycle is impossible (single grant).
- Address wrap: addresses use ADDR_W bits only; there is no range checking.

Test Plan:
- Reset: assert resetn=0 mid-read (if granted, cycle before) -> if_rvalid stays 0 after release; all gnt=0, cpu_hold=0.
- Priority: if_req=1 addr 3, dm_req=1 dm_we=0 addr 7 (same cycle) -> dm_gnt=1, ram_addr=7; next cycle dm_rvalid=1, rdata=mem[7], if_gnt=0.
- Starvation: dm_req and if_req held high with STARVE_LIMIT=4 -> dm granted cycles 0-3, if_gnt=1 in cycle 4, dm granted cycle 5, pattern repeats every 5 cycles.
- Load entry: fetch read granted at cycle N and load_mode raised at N -> DRAIN at N+1 with if_rvalid=1 and cpu_hold=1; LOAD at N+2; ld_req write 16'hBEEF to addr 31 -> ram_we=1, ram_addr=31.
- Loader exclusivity/readback: in LOAD, dm_req=1 and ld_req read addr 31 -> dm_gnt=0; next cycle ld_rvalid=1, rdata=16'hBEEF. Outside LOAD, ld_req=1 -> ld_gnt=0.
- Load exit: drop load_mode while ld_req read is granted -> next cycle state RUN, cpu_hold=0, ld_rvalid=1; the same cycle's if_req is granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three requesters, the shared RAM and mem_port_arbiter.
// slave = arbiter side; master = requesters plus RAM.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              load_mode;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rdata;
  logic              cpu_hold;

  modport slave (
    input  load_mode,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid,
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output rdata, cpu_hold
  );

  modport master (
    output load_mode,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid,
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  rdata, cpu_hold
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: data beats fetch except after STARVE_LIMIT denials;
// a RUN/DRAIN/LOAD FSM hands the port exclusively to the program loader.
module mem_port_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [1:0] OWN_LD   = 2'd3;

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve, w_starve_nxt;
  logic [1:0]       r_owner, w_owner_nxt;
  logic             w_ld_gnt, w_dm_gnt, w_if_gnt;
  logic             w_fetch_pri;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_gnt    = 1'b0;
    w_fetch_pri = (r_starve == LIMIT);
    case (r_state)
      ST_RUN: begin
        // A saturated counter implies fetch was pending; it only overrides while still requesting.
        w_dm_gnt = bus.dm_req && !(bus.if_req && w_fetch_pri);
        w_if_gnt = bus.if_req && !w_dm_gnt;
        if (bus.load_mode) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = bus.load_mode ? ST_LOAD : ST_RUN;
      ST_LOAD: begin
        w_ld_gnt = bus.ld_req;
        if (!bus.load_mode) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (r_state == ST_LOAD || !bus.if_req || w_if_gnt)
      w_starve_nxt = '0;
    else if (r_starve != LIMIT)
      w_starve_nxt = r_starve + CNT_W'(1);
  end

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    w_owner_nxt   = OWN_NONE;
    if (w_ld_gnt) begin
      bus.ram_we    = bus.ld_we;
      bus.ram_addr  = bus.ld_addr;
      bus.ram_wdata = bus.ld_wdata;
      w_owner_nxt   = bus.ld_we ? OWN_NONE : OWN_LD;
    end else if (w_dm_gnt) begin
      bus.ram_we    = bus.dm_we;
      bus.ram_addr  = bus.dm_addr;
      bus.ram_wdata = bus.dm_wdata;
      w_owner_nxt   = bus.dm_we ? OWN_NONE : OWN_DM;
    end else if (w_if_gnt) begin
      bus.ram_addr  = bus.if_addr;
      w_owner_nxt   = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_RUN;
      r_starve <= '0;
      r_owner  <= OWN_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_gnt    = w_if_gnt;
  assign bus.ld_rvalid = (r_owner == OWN_LD);
  assign bus.dm_rvalid = (r_owner == OWN_DM);
  assign bus.if_rvalid = (r_owner == OWN_IF);
  assign bus.rdata     = bus.ram_rdata;
  assign bus.cpu_hold  = (r_state != ST_RUN);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32x16 synchronous-read RAM.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] mem [32];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    bus.ram_rdata  = '0;
    bus.load_mode  = 1'b0;
    idle_inputs();
    resetn = 1'b0;
    #1;
    chk("rst_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 0);
    chk("rst_rvalid", {bus.ld_rvalid, bus.dm_rvalid, bus.if_rvalid}, 0);
    chk("rst_hold", bus.cpu_hold, 0);
    chk("rst_ram", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Fetch read granted, then reset lands before its response cycle.
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 5'd2; #1;
    chk("pre_rst_if_gnt", bus.if_gnt, 1);
    @(posedge clk); #2; resetn = 1'b0; bus.if_req = 1'b0; #1;
    chk("rst_mid_if_rvalid", bus.if_rvalid, 0);
    @(negedge clk); resetn = 1'b1; #1;
    chk("rel_if_rvalid", bus.if_rvalid, 0);
    @(negedge clk); #1;
    chk("rel2_if_rvalid", bus.if_rvalid, 0);
    chk("rel_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 0);
    chk("rel_hold", bus.cpu_hold, 0);

    // Priority + starvation: both held high, fetch wins every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 5'd3;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 5'd7;
      #1;
      chk($sformatf("starve_if_gnt_%0d", k), bus.if_gnt, ((k % 5) == 4) ? 1 : 0);
      chk($sformatf("starve_dm_gnt_%0d", k), bus.dm_gnt, ((k % 5) == 4) ? 0 : 1);
      chk($sformatf("starve_ram_addr_%0d", k), bus.ram_addr, ((k % 5) == 4) ? 3 : 7);
      if (k > 0) begin
        chk($sformatf("starve_if_rv_%0d", k), bus.if_rvalid, (((k - 1) % 5) == 4) ? 1 : 0);
        chk($sformatf("starve_dm_rv_%0d", k), bus.dm_rvalid, (((k - 1) % 5) == 4) ? 0 : 1);
        chk($sformatf("starve_rdata_%0d", k), bus.rdata, (((k - 1) % 5) == 4) ? 32'h1003 : 32'h1007);
      end
    end
    @(negedge clk); idle_inputs(); #1;
    chk("tail_if_rvalid", bus.if_rvalid, 1);
    chk("tail_rdata", bus.rdata, 32'h1003);
    chk("idle_ram", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);

    // Data write then readback.
    @(negedge clk); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 5'd5; bus.dm_wdata = 16'h5555; #1;
    chk("dmw_gnt", bus.dm_gnt, 1);
    chk("dmw_ram", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {1'b1, 5'd5, 16'h5555});
    @(negedge clk); bus.dm_we = 1'b0; #1;
    chk("dmw_no_rvalid", bus.dm_rvalid, 0);
    chk("dmr_ram_we", bus.ram_we, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("dmr_rvalid", bus.dm_rvalid, 1);
    chk("dmr_rdata", bus.rdata, 32'h5555);
    @(negedge clk); bus.ld_req = 1'b1; #1;
    chk("run_ld_gnt", bus.ld_gnt, 0);

    // Load entry: fetch granted in the same cycle load_mode rises.
    @(negedge clk); idle_inputs(); bus.if_req = 1'b1; bus.if_addr = 5'd4; bus.load_mode = 1'b1; #1;
    chk("entry_if_gnt", bus.if_gnt, 1);
    chk("entry_hold", bus.cpu_hold, 0);
    @(negedge clk); bus.dm_req = 1'b1; #1;
    chk("drain_hold", bus.cpu_hold, 1);
    chk("drain_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 0);
    chk("drain_if_rvalid", bus.if_rvalid, 1);
    chk("drain_rdata", bus.rdata, 32'h1004);
    @(negedge clk); bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 5'd31; bus.ld_wdata = 16'hBEEF; #1;
    chk("load_hold", bus.cpu_hold, 1);
    chk("load_w_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b100);
    chk("load_w_ram", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {1'b1, 5'd31, 16'hBEEF});
    chk("load_if_rvalid_pulse", bus.if_rvalid, 0);
    @(negedge clk); bus.ld_we = 1'b0; #1;
    chk("load_r_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b100);
    chk("load_w_no_rvalid", bus.ld_rvalid, 0);
    @(negedge clk); bus.ld_req = 1'b0; #1;
    chk("load_rvalid", bus.ld_rvalid, 1);
    chk("load_rdata", bus.rdata, 32'hBEEF);
    chk("load_dm_gnt", bus.dm_gnt, 0);

    // Load exit with a loader read granted in the final LOAD cycle.
    @(negedge clk); bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.ld_req = 1'b1; bus.ld_addr = 5'd0; bus.load_mode = 1'b0; #1;
    chk("exit_ld_gnt", bus.ld_gnt, 1);
    chk("exit_hold_last", bus.cpu_hold, 1);
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 5'd1; #1;
    chk("exit_hold", bus.cpu_hold, 0);
    chk("exit_ld_rvalid", bus.ld_rvalid, 1);
    chk("exit_rdata", bus.rdata, 32'h1000);
    chk("exit_gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b001);
    @(negedge clk); idle_inputs(); #1;
    chk("exit_if_rvalid", bus.if_rvalid, 1);
    chk("exit_if_rdata", bus.rdata, 32'h1001);
    chk("exit_ld_rvalid_pulse", bus.ld_rvalid, 0);

    // One-cycle load_mode pulse: DRAIN then straight back to RUN.
    @(negedge clk); bus.load_mode = 1'b1; #1;
    chk("pulse_run_hold", bus.cpu_hold, 0);
    @(negedge clk); bus.load_mode = 1'b0; bus.dm_req = 1'b1; #1;
    chk("pulse_drain_hold", bus.cpu_hold, 1);
    chk("pulse_drain_dm_gnt", bus.dm_gnt, 0);
    @(negedge clk); #1;
    chk("pulse_back_hold", bus.cpu_hold, 0);
    chk("pulse_back_dm_gnt", bus.dm_gnt, 1);
    @(negedge clk); idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
